// File: rtl/move_cmd_gen_pkg.sv
// Shared game definitions: move directions, move-generator states and counter helpers.
// The same direction encoding is used by the player and path-finding blocks.
package move_cmd_gen_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DELAY  = 2'd2,
        ST_REPEAT = 2'd3
    } move_state_t;

    localparam int CNT_W = 24;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Terminal count for a span of 'cycles' cycles, clamped to what the counter can hold.
    function automatic logic [CNT_W-1:0] term_count(input int unsigned cycles);
        if (cycles == 32'd0)
            return '0;
        if (cycles > 32'h0100_0000)
            return CNT_MAX;
        return CNT_W'(cycles - 32'd1);
    endfunction

endpackage

// File: rtl/move_cmd_gen_sync2.sv
// Two-flop synchroniser for one asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/move_cmd_gen.sv
// Turns held buttons/keys into single move requests with hold-to-repeat.
// state  | meaning
// IDLE   | nothing held (or waiting for the pending move to drain)
// ISSUE  | a repeat move was just raised
// DELAY  | direction held, waiting for auto-repeat to start
// REPEAT | auto-repeating every REPEAT_PERIOD cycles
module move_cmd_gen
    import move_cmd_gen_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 32'd6_000_000,
    parameter int unsigned REPEAT_PERIOD = 32'd2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       enable,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       held_any
);

    localparam logic [CNT_W-1:0] DELAY_TERM  = term_count(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_TERM = term_count(REPEAT_PERIOD);

    logic [3:0]       w_raw;
    logic [3:0]       w_held;
    logic             w_any;
    dir_t             w_cur_dir;

    move_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_valid, w_valid_nxt;
    dir_t             r_dir, w_dir_nxt;
    logic             w_slot_free;
    logic             w_issue;

    assign w_raw = {btn_right | key_right, btn_left | key_left,
                    btn_down | key_down, btn_up | key_up};

    for (genvar g = 0; g < 4; g++) begin : g_sync
        sync2 u_sync2 (
            .clk (clk),
            .rst (rst),
            .d   (w_raw[g]),
            .q   (w_held[g])
        );
    end

    assign w_any = |w_held;

    always_comb begin
        w_cur_dir = DIR_UP;
        if (w_held[0])
            w_cur_dir = DIR_UP;
        else if (w_held[1])
            w_cur_dir = DIR_DOWN;
        else if (w_held[2])
            w_cur_dir = DIR_LEFT;
        else if (w_held[3])
            w_cur_dir = DIR_RIGHT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_dir   <= DIR_UP;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid && !move_ready;
        w_dir_nxt   = r_dir;
        w_issue     = 1'b0;
        w_slot_free = !r_valid || move_ready;
        w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 24'd1;

        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b0;
        end else if (!w_any) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_IDLE || w_cur_dir != r_dir) begin
            // Fresh press or new winner; a superseded pending move must drain first.
            w_cnt_nxt = '0;
            if (w_slot_free) begin
                w_issue     = 1'b1;
                w_state_nxt = ST_DELAY;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else if (r_state == ST_DELAY) begin
            if (r_cnt == DELAY_TERM) begin
                w_state_nxt = ST_REPEAT;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = w_cnt_inc;
            end
        end else begin
            // Period counter wraps freely; the tick sits at count 0 so the first
            // repeat follows the hold delay directly. Busy ticks are dropped.
            w_cnt_nxt = (r_cnt == PERIOD_TERM) ? '0 : w_cnt_inc;
            if (r_cnt == '0 && w_slot_free) begin
                w_issue     = 1'b1;
                w_state_nxt = ST_ISSUE;
            end else begin
                w_state_nxt = ST_REPEAT;
            end
        end

        if (w_issue) begin
            w_valid_nxt = 1'b1;
            w_dir_nxt   = w_cur_dir;
        end
    end

    assign move_valid = r_valid;
    assign move_dir   = r_dir;
    assign held_any   = w_any;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Scoreboard bench for move_cmd_gen with REPEAT_DELAY=8, REPEAT_PERIOD=4.
module tb_move_cmd_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       key_up, key_down, key_left, key_right;
    logic       enable, move_ready;
    logic       move_valid, held_any;
    logic [1:0] move_dir;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;
    int t0;

    typedef struct {
        int dir;
        int at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    move_cmd_gen #(
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_left   (key_left),
        .key_right  (key_right),
        .enable     (enable),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .held_any   (held_any)
    );

    task automatic check(input string name, input int act, input int expv);
        n_total++;
        if (act == expv)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // bit order {right, left, down, up}
    task automatic drive(input logic [3:0] btn, input logic [3:0] key);
        {btn_right, btn_left, btn_down, btn_up} = btn;
        {key_right, key_left, key_down, key_up} = key;
    endtask

    task automatic expect_move(input int dir, input int at);
        exp_q.push_back('{dir, at});
    endtask

    task automatic drain(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every accepted move must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && move_valid && move_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_move_dir", int'(move_dir), -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("move_dir", int'(move_dir), mon_e.dir);
                check("move_cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    typedef struct {
        logic [3:0] btn;
        logic [3:0] key;
        int         dir;
    } prio_t;

    prio_t prio_tab[4];

    initial begin
        prio_tab[0] = '{4'b0110, 4'b1000, 1};
        prio_tab[1] = '{4'b1000, 4'b0100, 2};
        prio_tab[2] = '{4'b0000, 4'b1000, 3};
        prio_tab[3] = '{4'b0001, 4'b1110, 0};

        // Reset state, including a key held during reset
        rst = 1'b1;
        enable = 1'b1;
        move_ready = 1'b1;
        drive(4'b0000, 4'b0001);
        #2;
        check("rst_valid", int'(move_valid), 0);
        check("rst_dir", int'(move_dir), 0);
        check("rst_held", int'(held_any), 0);
        tick(3);
        check("rst_held_key", int'(held_any), 0);
        check("rst_valid_key", int'(move_valid), 0);
        drive(4'b0000, 4'b0000);
        rst = 1'b0;
        tick(2);

        // Hold key_up 20 cycles: moves at +3, +12, +16, +20
        t0 = cyc;
        drive(4'b0000, 4'b0001);
        expect_move(0, t0 + 3);
        expect_move(0, t0 + 12);
        expect_move(0, t0 + 16);
        expect_move(0, t0 + 20);
        tick(1);
        check("sync_held_c1", int'(held_any), 0);
        tick(1);
        check("sync_held_c2", int'(held_any), 1);
        tick(18);
        drive(4'b0000, 4'b0000);
        tick(8);
        drain("repeat_all_seen");

        // Stalled handshake: btn_left held stable 10 cycles, then one accept
        move_ready = 1'b0;
        t0 = cyc;
        drive(4'b0100, 4'b0000);
        expect_move(2, t0 + 12);
        tick(3);
        for (int i = 0; i < 10; i++) begin
            if (i == 1)
                drive(4'b0000, 4'b0000);
            check("stall_valid", int'(move_valid), 1);
            check("stall_dir", int'(move_dir), 2);
            if (i == 9)
                move_ready = 1'b1;
            tick(1);
        end
        check("stall_drop", int'(move_valid), 0);
        tick(6);
        drain("stall_one_accept");

        // Direction change: right, then up added at +5 restarts DELAY
        t0 = cyc;
        drive(4'b1000, 4'b0000);
        expect_move(3, t0 + 3);
        expect_move(0, t0 + 8);
        expect_move(0, t0 + 17);
        tick(5);
        drive(4'b1000, 4'b0001);
        tick(13);
        drive(4'b0000, 4'b0000);
        tick(8);
        drain("change_all_seen");

        // Enable drop clears the pending move and blocks further moves
        move_ready = 1'b0;
        t0 = cyc;
        drive(4'b0010, 4'b0000);
        tick(4);
        check("en_valid_before", int'(move_valid), 1);
        check("en_dir_before", int'(move_dir), 1);
        enable = 1'b0;
        tick(1);
        check("en_valid_cleared", int'(move_valid), 0);
        move_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            check("en_no_move", int'(move_valid), 0);
        end
        drive(4'b0000, 4'b0000);
        tick(3);
        enable = 1'b1;
        tick(3);
        drain("en_none_expected");

        // Async reset mid-handshake, then fresh press latency after release
        move_ready = 1'b0;
        drive(4'b0000, 4'b1000);
        tick(4);
        check("rst_mid_valid_before", int'(move_valid), 1);
        check("rst_mid_dir_before", int'(move_dir), 3);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid_async", int'(move_valid), 0);
        check("rst_mid_dir_async", int'(move_dir), 0);
        tick(2);
        rst = 1'b0;
        move_ready = 1'b1;
        t0 = cyc;
        expect_move(3, t0 + 3);
        tick(2);
        check("rst_mid_latency", int'(move_valid), 0);
        tick(2);
        drive(4'b0000, 4'b0000);
        tick(8);
        drain("rst_mid_reissue");

        // Single-cycle press still yields exactly one move
        t0 = cyc;
        drive(4'b0001, 4'b0000);
        expect_move(0, t0 + 3);
        tick(1);
        drive(4'b0000, 4'b0000);
        tick(8);
        drain("pulse_one_move");

        // Priority up > down > left > right across btn/key mixes
        for (int p = 0; p < 4; p++) begin
            t0 = cyc;
            drive(prio_tab[p].btn, prio_tab[p].key);
            expect_move(prio_tab[p].dir, t0 + 3);
            tick(3);
            drive(4'b0000, 4'b0000);
            tick(6);
            drain("prio_seen");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/move_cmd_gen.md
MOVE_CMD_GEN -- requirements
Module: move_cmd_gen

Interface
REQ-001 The block SHALL have parameter REPEAT_DELAY, default 24'd6_000_000, meaning the cycles a direction is held before auto-repeat starts.
REQ-002 The block SHALL have parameter REPEAT_PERIOD, default 24'd2_500_000, meaning the cycles between auto-repeat moves.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have the port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have the ports btn_up, btn_down, btn_left, btn_right, each input, 1 bit: debounced push-button levels, asynchronous to clk.
REQ-006 The block SHALL have the ports key_up, key_down, key_left, key_right, each input, 1 bit: PS2 key-held levels for scan codes 75/72/6B/74.
REQ-007 The block SHALL have the port enable, input, 1 bit: player_alive; when low, no moves are issued.
REQ-008 The block SHALL have the port move_ready, input, 1 bit: the player stage accepts a move.
REQ-009 The block SHALL have the port move_valid, output, 1 bit: a move request is pending.
REQ-010 The block SHALL have the port move_dir, output, 2 bits: 0=up, 1=down, 2=left, 3=right; valid while move_valid is high.
REQ-011 The block SHALL have the port held_any, output, 1 bit: at least one direction is held after synchronisation.

Function
REQ-012 Each direction SHALL equal btn_x OR key_x, passed through a 2-flop synchroniser on clk.
REQ-013 Priority SHALL be up > down > left > right; the winning direction is cur_dir.
REQ-014 The FSM SHALL have four states: IDLE, ISSUE, DELAY and REPEAT.
REQ-015 In IDLE, a synchronised direction with enable=1 SHALL capture cur_dir, raise move_valid on the next edge, and go to DELAY.
REQ-016 move_valid SHALL rise on the 3rd rising clk edge after an input rises; the 2 synchroniser edges plus 1 register edge give a latency of 3.
REQ-017 In DELAY, a 24-bit counter SHALL count from 0; at REPEAT_DELAY-1 the FSM goes to REPEAT and the counter clears.
REQ-018 In REPEAT, each time the counter reaches REPEAT_PERIOD-1 the FSM SHALL enter ISSUE (which asserts move_valid) and then return to REPEAT.
REQ-019 Handshake: once raised, move_valid and move_dir SHALL hold stable until a cycle with move_valid && move_ready; move_valid drops on the next edge unless a new issue coincides.
REQ-020 At most one move SHALL be outstanding; a repeat tick while move_valid=1 is dropped, not queued, and the counter continues wrapping.
REQ-021 If the held direction changes to a different winner, the FSM SHALL behave as a fresh press: issue the new direction and restart DELAY.
REQ-022 A pending move whose direction is superseded SHALL still complete its handshake before the new move is raised.
REQ-023 When all directions are released, the FSM SHALL return to IDLE and the counter clears; any pending move stays until accepted.
REQ-024 If enable is low, the FSM SHALL be forced to IDLE, a pending move_valid is cleared immediately, and no move is issued.
REQ-025 A press and release within a single cycle, if seen by the synchroniser, SHALL still issue exactly one move.
REQ-026 The counter SHALL saturate, never wrap, if a parameter exceeds 2^24-1.

Reset
REQ-027 While rst=1, the FSM SHALL be IDLE, the counter 0, the synchronisers 0, and move_valid=0, move_dir=0, held_any=0.
REQ-028 Reset asserted mid-handshake SHALL drop move_valid asynchronously; after release, a held key is treated as a fresh press (latency of 3 again).

Structure
REQ-029 The direction encoding (DIR_UP..DIR_RIGHT) and the state encodings SHALL live in the shared game package, also used by player and bellman_ford_shortest_path.
REQ-030 The 2-flop synchroniser SHALL be one sub-module, sync2, instantiated once per direction.

Verification
REQ-031 With REPEAT_DELAY=8 and REPEAT_PERIOD=4 and move_ready tied 1: hold key_up for 20 cycles -> move_dir=0 pulses at cycle 3, then cycle 12, then every 4 cycles.
REQ-032 With move_ready=0: press btn_left -> move_valid=1 and move_dir=2 held stable for 10 cycles; raise move_ready -> exactly 1 accepted move.
REQ-033 Hold btn_right, then add key_up at cycle 5 -> the next move is dir 0, and DELAY restarts from that point.
REQ-034 Hold btn_down, then drop enable at cycle 4 -> move_valid=0 on the next edge and no further moves while enable=0.
REQ-035 Assert rst while move_valid=1 with a key held -> move_valid=0 immediately; after release, move_valid=1 after 3 edges with the same direction.
